// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared widths and types for the demux_1x8 block.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int SEL_W = 3;
    localparam int N_OUT = 8;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [N_OUT-1:0] dout_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_1x8_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x8_if
// Description : Data/select inputs and the eight routed outputs of demux_1x8.
//               onehot_err exists only when DEMUX_ONEHOT_CHK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_1x8_if;
    import demux_pkg::*;

    logic a;
    sel_t b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
    logic h;
    logic i;
    logic j;
`ifdef DEMUX_ONEHOT_CHK_EN
    logic onehot_err;
`endif

    modport master (
        output a, b,
        input  c, d, e, f, g, h, i, j
`ifdef DEMUX_ONEHOT_CHK_EN
        , input onehot_err
`endif
    );

    modport slave (
        input  a, b,
        output c, d, e, f, g, h, i, j
`ifdef DEMUX_ONEHOT_CHK_EN
        , output onehot_err
`endif
    );

endinterface : demux_1x8_if
`default_nettype wire

// File: rtl/demux_dec.sv
`default_nettype none
// ============================================================================
// Module      : demux_dec
// Description : Combinational 1-to-N decode: a one-hot-or-zero vector with
//               the data bit placed at the selected position.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_dec
    import demux_pkg::*;
(
    input  wire sel_t  sel,
    input  wire logic  din,
    output dout_t      dout
);

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign dout[k] = din & (sel == sel_t'(k));
    end

endmodule : demux_dec
`default_nettype wire

// File: rtl/demux_1x8.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x8
// Description : Registered 1-to-8 demultiplexer, one cycle latency.
//               Optional DEMUX_ONEHOT_CHK_EN adds a registered onehot_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1x8
    import demux_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    demux_1x8_if.slave  bus
);

    dout_t w_dec;
    dout_t r_dout;

    demux_dec u_dec (
        .sel  (bus.b),
        .din  (bus.a),
        .dout (w_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else begin
            r_dout <= w_dec;
        end
    end

    assign bus.c = r_dout[0];
    assign bus.d = r_dout[1];
    assign bus.e = r_dout[2];
    assign bus.f = r_dout[3];
    assign bus.g = r_dout[4];
    assign bus.h = r_dout[5];
    assign bus.i = r_dout[6];
    assign bus.j = r_dout[7];

`ifdef DEMUX_ONEHOT_CHK_EN
    // x & (x-1) clears the lowest set bit; nonzero means two or more bits set.
    logic w_multi_hot;
    logic r_onehot_err;

    assign w_multi_hot = |(r_dout & (r_dout - dout_t'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_onehot_err <= 1'b0;
        end else begin
            r_onehot_err <= w_multi_hot;
        end
    end

    assign bus.onehot_err = r_onehot_err;
`endif

endmodule : demux_1x8
`default_nettype wire

// File: tb/tb_demux_1x8.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1x8
// Description : Self-checking bench for demux_1x8 (vector table, corner
//               sequences, random stream against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1x8;

    typedef struct {
        logic       a;
        logic [2:0] b;
        logic [7:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t vecs [16];

    demux_1x8_if bus ();

    demux_1x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {bus.j, bus.i, bus.h, bus.g, bus.f, bus.e, bus.d, bus.c};
    endfunction

    task automatic check(input string nm, input logic [7:0] exp);
        total++;
        if (outs() !== exp) begin
            bad++;
            $display("FAIL %s: outputs(j..c) got %b want %b at %0t", nm, outs(), exp, $time);
        end
`ifdef DEMUX_ONEHOT_CHK_EN
        total++;
        if (bus.onehot_err !== 1'b0) begin
            bad++;
            $display("FAIL %s_onehot_err: got %b want 0 at %0t", nm, bus.onehot_err, $time);
        end
`endif
    endtask

    // Apply inputs away from the edge, clock once, check just after the edge.
    task automatic step(input logic ai, input logic [2:0] bi, input logic [7:0] exp,
                        input string nm);
        bus.a = ai;
        bus.b = bi;
        @(posedge clk);
        #1;
        check(nm, exp);
    endtask

    initial begin
        logic       ra;
        logic [2:0] rb;
        logic [7:0] model;

        total = 0;
        bad   = 0;

        vecs[0]  = '{1'b1, 3'd0, 8'h01};
        vecs[1]  = '{1'b1, 3'd1, 8'h02};
        vecs[2]  = '{1'b1, 3'd2, 8'h04};
        vecs[3]  = '{1'b1, 3'd3, 8'h08};
        vecs[4]  = '{1'b1, 3'd4, 8'h10};
        vecs[5]  = '{1'b1, 3'd5, 8'h20};
        vecs[6]  = '{1'b1, 3'd6, 8'h40};
        vecs[7]  = '{1'b1, 3'd7, 8'h80};
        vecs[8]  = '{1'b0, 3'd0, 8'h00};
        vecs[9]  = '{1'b0, 3'd1, 8'h00};
        vecs[10] = '{1'b0, 3'd2, 8'h00};
        vecs[11] = '{1'b0, 3'd3, 8'h00};
        vecs[12] = '{1'b0, 3'd4, 8'h00};
        vecs[13] = '{1'b0, 3'd5, 8'h00};
        vecs[14] = '{1'b0, 3'd6, 8'h00};
        vecs[15] = '{1'b0, 3'd7, 8'h00};

        // Reset with active-looking inputs: outputs zero without any clock edge.
        rst_n = 1'b0;
        bus.a = 1'b1;
        bus.b = 3'b101;
        #2;
        check("reset_no_clk", 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_held", 8'h00);
        rst_n = 1'b1;
        #2;
        check("release_before_edge", 8'h00);
        @(posedge clk);
        #1;
        check("first_edge_h", 8'h20);

        for (int k = 0; k < 16; k++) begin
            step(vecs[k].a, vecs[k].b, vecs[k].exp, $sformatf("vec%0d", k));
        end

        // Latency: select change between edges does not reach the outputs early.
        step(1'b1, 3'd0, 8'h01, "lat_c");
        bus.b = 3'd7;
        #3;
        check("lat_c_hold", 8'h01);
        @(posedge clk);
        #1;
        check("lat_j", 8'h80);

        // Mid-stream reset with j high.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_async", 8'h00);
        @(posedge clk);
        #1;
        check("midrst_held", 8'h00);
        #2;
        rst_n = 1'b1;
        #1;
        check("midrst_release", 8'h00);
        @(posedge clk);
        #1;
        check("midrst_first_edge", 8'h80);

        // Random stream vs. reference: exactly the selected bit carries a.
        for (int n = 0; n < 1000; n++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 3'($urandom_range(0, 7));
            model = 8'h00;
            if (ra) model[rb] = 1'b1;
            step(ra, rb, model, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_demux_1x8
`default_nettype wire
